decode_stage: RTL and testbench

- Parametrised RV32 decode stage between fetch (s1) and execute (s3); successor to the first-generation decode block.
- Integrates the architectural register file and a valid/ready handshake on both sides.
- Adds flush, stall-hold with writeback snooping, RV32E support and illegal-instruction detection.
- One-cycle registered latency from fetch handshake to execute-side outputs.

---
 rtl/decode_pkg.sv | 40 ++++
 rtl/register_file.sv | 42 ++++
 rtl/decode_stage.sv | 198 +++++++++++++++++++
 tb/tb_decode_stage.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// decode_pkg: shared types and opcode constants for the RV32 decode stage.
package decode_pkg;

  typedef enum logic [3:0] {
    OP_LUI     = 4'd0,
    OP_AUIPC   = 4'd1,
    OP_JAL     = 4'd2,
    OP_JALR    = 4'd3,
    OP_BRANCH  = 4'd4,
    OP_LOAD    = 4'd5,
    OP_STORE   = 4'd6,
    OP_OPIMM   = 4'd7,
    OP_OP      = 4'd8,
    OP_FENCE   = 4'd9,
    OP_SYSTEM  = 4'd10,
    OP_ILLEGAL = 4'd11
  } op_class_t;

  typedef enum logic [2:0] {
    IMM_I    = 3'd0,
    IMM_S    = 3'd1,
    IMM_B    = 3'd2,
    IMM_U    = 3'd3,
    IMM_J    = 3'd4,
    IMM_NONE = 3'd5
  } imm_fmt_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

endpackage

// File: rtl/register_file.sv
// register_file: NREG x XLEN architectural registers, two combinational read
// ports, one synchronous write port, x0 hardwired to zero. NREG is 16 or 32;
// with 16 entries, indices with bit 4 set read zero and are never written.
module register_file #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      i_rs1_idx,
  input  logic [4:0]      i_rs2_idx,
  output logic [XLEN-1:0] o_rs1_dat,
  output logic [XLEN-1:0] o_rs2_dat,
  input  logic            i_we,
  input  logic [4:0]      i_wr_idx,
  input  logic [XLEN-1:0] i_wr_dat
);

  localparam int RIDX_W = $clog2(NREG);

  logic [XLEN-1:0] r_mem [NREG];
  logic            w_rs1_ok;
  logic            w_rs2_ok;
  logic            w_wr_ok;

  assign w_rs1_ok = (i_rs1_idx != 5'd0) && ((NREG == 32) || !i_rs1_idx[4]);
  assign w_rs2_ok = (i_rs2_idx != 5'd0) && ((NREG == 32) || !i_rs2_idx[4]);
  assign w_wr_ok  = (i_wr_idx  != 5'd0) && ((NREG == 32) || !i_wr_idx[4]);

  assign o_rs1_dat = w_rs1_ok ? r_mem[i_rs1_idx[RIDX_W-1:0]] : '0;
  assign o_rs2_dat = w_rs2_ok ? r_mem[i_rs2_idx[RIDX_W-1:0]] : '0;

  // Clear all entries on reset, otherwise perform the single registered write
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) r_mem[i] <= '0;
    end else if (i_we && w_wr_ok) begin
      r_mem[i_wr_idx[RIDX_W-1:0]] <= i_wr_dat;
    end
  end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: RV32I/RV32E decode between fetch and execute with one
// registered cycle of latency, valid/ready on both sides, flush, and
// writeback snooping while the output is stalled.
// Build macro DECODE_RF_BYPASS_EN: when defined, a writeback in the accept
// cycle is forwarded into the captured operands (write-through bypass).
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid_i,
  output logic            if_ready_o,
  input  logic [31:0]     if_instr_i,
  input  logic [XLEN-1:0] if_pc_i,
  output logic            ex_valid_o,
  input  logic            ex_ready_i,
  output logic [XLEN-1:0] ex_pc_o,
  output logic [31:0]     ex_instr_o,
  output logic [4:0]      ex_rs1_idx_o,
  output logic [4:0]      ex_rs2_idx_o,
  output logic [4:0]      ex_rd_idx_o,
  output logic [XLEN-1:0] ex_rs1_dat_o,
  output logic [XLEN-1:0] ex_rs2_dat_o,
  output logic [XLEN-1:0] ex_imm_o,
  output logic [3:0]      ex_op_o,
  output logic [2:0]      ex_funct3_o,
  output logic            ex_illegal_o,
  input  logic            wb_we_i,
  input  logic [4:0]      wb_rd_i,
  input  logic [XLEN-1:0] wb_dat_i,
  input  logic            flush_i
);

  logic [XLEN-1:0]    w_rf_rs1;
  logic [XLEN-1:0]    w_rf_rs2;
  logic [XLEN-1:0]    w_rs1_dat;
  logic [XLEN-1:0]    w_rs2_dat;
  op_class_t          w_op_raw;
  op_class_t          w_op;
  imm_fmt_t           w_fmt;
  logic               w_use_rs1;
  logic               w_use_rs2;
  logic               w_use_rd;
  logic               w_rv32e_bad;
  logic               w_illegal;
  logic signed [31:0] w_imm32;
  logic [XLEN-1:0]    w_imm;
  logic               w_accept;
  logic               w_hold;
  logic               w_snoop1;
  logic               w_snoop2;

  logic               r_vld_p1;
  logic [XLEN-1:0]    r_pc_p1;
  logic [31:0]        r_instr_p1;
  logic [4:0]         r_rs1_idx_p1;
  logic [4:0]         r_rs2_idx_p1;
  logic [4:0]         r_rd_idx_p1;
  logic [XLEN-1:0]    r_rs1_dat_p1;
  logic [XLEN-1:0]    r_rs2_dat_p1;
  logic [XLEN-1:0]    r_imm_p1;
  logic [3:0]         r_op_p1;
  logic [2:0]         r_funct3_p1;
  logic               r_illegal_p1;

  register_file #(.XLEN(XLEN), .NREG(NREG)) u_rf (
    .clk       (clk),
    .rst       (rst),
    .i_rs1_idx (if_instr_i[19:15]),
    .i_rs2_idx (if_instr_i[24:20]),
    .o_rs1_dat (w_rf_rs1),
    .o_rs2_dat (w_rf_rs2),
    .i_we      (wb_we_i),
    .i_wr_idx  (wb_rd_i),
    .i_wr_dat  (wb_dat_i)
  );

`ifdef DECODE_RF_BYPASS_EN
  assign w_rs1_dat = (wb_we_i && (wb_rd_i != 5'd0) && (wb_rd_i == if_instr_i[19:15]))
                     ? wb_dat_i : w_rf_rs1;
  assign w_rs2_dat = (wb_we_i && (wb_rd_i != 5'd0) && (wb_rd_i == if_instr_i[24:20]))
                     ? wb_dat_i : w_rf_rs2;
`else
  assign w_rs1_dat = w_rf_rs1;
  assign w_rs2_dat = w_rf_rs2;
`endif

  // Classify the opcode and note which register fields it actually uses
  always_comb begin
    w_op_raw  = OP_ILLEGAL;
    w_fmt     = IMM_NONE;
    w_use_rs1 = 1'b0;
    w_use_rs2 = 1'b0;
    w_use_rd  = 1'b0;
    case (if_instr_i[6:0])
      OPC_LUI:    begin w_op_raw = OP_LUI;    w_fmt = IMM_U; w_use_rd = 1'b1; end
      OPC_AUIPC:  begin w_op_raw = OP_AUIPC;  w_fmt = IMM_U; w_use_rd = 1'b1; end
      OPC_JAL:    begin w_op_raw = OP_JAL;    w_fmt = IMM_J; w_use_rd = 1'b1; end
      OPC_JALR:   begin w_op_raw = OP_JALR;   w_fmt = IMM_I; w_use_rs1 = 1'b1; w_use_rd = 1'b1; end
      OPC_BRANCH: begin w_op_raw = OP_BRANCH; w_fmt = IMM_B; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; end
      OPC_LOAD:   begin w_op_raw = OP_LOAD;   w_fmt = IMM_I; w_use_rs1 = 1'b1; w_use_rd = 1'b1; end
      OPC_STORE:  begin w_op_raw = OP_STORE;  w_fmt = IMM_S; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; end
      OPC_OPIMM:  begin w_op_raw = OP_OPIMM;  w_fmt = IMM_I; w_use_rs1 = 1'b1; w_use_rd = 1'b1; end
      OPC_OP:     begin w_op_raw = OP_OP;     w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; w_use_rd = 1'b1; end
      OPC_FENCE:  w_op_raw = OP_FENCE;
      OPC_SYSTEM: w_op_raw = OP_SYSTEM;
      default:    w_op_raw = OP_ILLEGAL;
    endcase
  end

  // RV32E has only x0..x15, so any used index with bit 4 set is illegal
  assign w_rv32e_bad = (NREG == 16) && ((w_use_rs1 && if_instr_i[19]) ||
                                        (w_use_rs2 && if_instr_i[24]) ||
                                        (w_use_rd  && if_instr_i[11]));
  assign w_illegal   = (if_instr_i[1:0] != 2'b11) || (w_op_raw == OP_ILLEGAL) || w_rv32e_bad;
  assign w_op        = w_illegal ? OP_ILLEGAL : w_op_raw;

  // Assemble the 32-bit immediate for the decoded format; illegal words give 0
  always_comb begin
    w_imm32 = '0;
    if (!w_illegal) begin
      case (w_fmt)
        IMM_I:   w_imm32 = {{20{if_instr_i[31]}}, if_instr_i[31:20]};
        IMM_S:   w_imm32 = {{20{if_instr_i[31]}}, if_instr_i[31:25], if_instr_i[11:7]};
        IMM_B:   w_imm32 = {{19{if_instr_i[31]}}, if_instr_i[31], if_instr_i[7],
                            if_instr_i[30:25], if_instr_i[11:8], 1'b0};
        IMM_U:   w_imm32 = {if_instr_i[31:12], 12'h000};
        IMM_J:   w_imm32 = {{11{if_instr_i[31]}}, if_instr_i[31], if_instr_i[19:12],
                            if_instr_i[20], if_instr_i[30:21], 1'b0};
        default: w_imm32 = '0;
      endcase
    end
  end

  assign w_imm = XLEN'(w_imm32);

  assign if_ready_o = !r_vld_p1 || ex_ready_i;
  assign w_accept   = if_valid_i && if_ready_o;
  assign w_hold     = r_vld_p1 && !ex_ready_i;
  assign w_snoop1   = wb_we_i && (wb_rd_i != 5'd0) && (wb_rd_i == r_rs1_idx_p1);
  assign w_snoop2   = wb_we_i && (wb_rd_i != 5'd0) && (wb_rd_i == r_rs2_idx_p1);

  // ---- stage boundary: decode -> execute (p1) ----
  // Capture on accept, hold with operand snooping while stalled; flush wins
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p1     <= 1'b0;
      r_pc_p1      <= '0;
      r_instr_p1   <= '0;
      r_rs1_idx_p1 <= '0;
      r_rs2_idx_p1 <= '0;
      r_rd_idx_p1  <= '0;
      r_rs1_dat_p1 <= '0;
      r_rs2_dat_p1 <= '0;
      r_imm_p1     <= '0;
      r_op_p1      <= '0;
      r_funct3_p1  <= '0;
      r_illegal_p1 <= 1'b0;
    end else if (flush_i) begin
      r_vld_p1 <= 1'b0;
    end else if (w_accept) begin
      r_vld_p1     <= 1'b1;
      r_pc_p1      <= if_pc_i;
      r_instr_p1   <= if_instr_i;
      r_rs1_idx_p1 <= if_instr_i[19:15];
      r_rs2_idx_p1 <= if_instr_i[24:20];
      r_rd_idx_p1  <= if_instr_i[11:7];
      r_rs1_dat_p1 <= w_rs1_dat;
      r_rs2_dat_p1 <= w_rs2_dat;
      r_imm_p1     <= w_imm;
      r_op_p1      <= w_op;
      r_funct3_p1  <= if_instr_i[14:12];
      r_illegal_p1 <= w_illegal;
    end else if (w_hold) begin
      if (w_snoop1) r_rs1_dat_p1 <= wb_dat_i;
      if (w_snoop2) r_rs2_dat_p1 <= wb_dat_i;
    end else begin
      r_vld_p1 <= 1'b0;
    end
  end

  assign ex_valid_o   = r_vld_p1;
  assign ex_pc_o      = r_pc_p1;
  assign ex_instr_o   = r_instr_p1;
  assign ex_rs1_idx_o = r_rs1_idx_p1;
  assign ex_rs2_idx_o = r_rs2_idx_p1;
  assign ex_rd_idx_o  = r_rd_idx_p1;
  assign ex_rs1_dat_o = r_rs1_dat_p1;
  assign ex_rs2_dat_o = r_rs2_dat_p1;
  assign ex_imm_o     = r_imm_p1;
  assign ex_op_o      = r_op_p1;
  assign ex_funct3_o  = r_funct3_p1;
  assign ex_illegal_o = r_illegal_p1;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: drives an RV32I (NREG=32) and an RV32E (NREG=16) instance
// with the same directed stimulus; a per-instance reference model is compared
// every cycle, and hand-computed literals pin key results.
`timescale 1ns/1ps
module tb_decode_stage;
  import decode_pkg::*;

`ifdef DECODE_RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_valid = 1'b0;
  logic [31:0] if_instr = '0;
  logic [31:0] if_pc = '0;
  logic        ex_ready = 1'b1;
  logic        wb_we = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_dat = '0;
  logic        flush = 1'b0;

  logic        o_vld [2];
  logic        o_rdy [2];
  logic        o_ill [2];
  logic [31:0] o_pc [2];
  logic [31:0] o_instr [2];
  logic [31:0] o_rs1d [2];
  logic [31:0] o_rs2d [2];
  logic [31:0] o_imm [2];
  logic [4:0]  o_rs1i [2];
  logic [4:0]  o_rs2i [2];
  logic [4:0]  o_rdi [2];
  logic [3:0]  o_op [2];
  logic [2:0]  o_f3 [2];

  int n_chk = 0;
  int n_fail = 0;
  bit mon_en = 1'b0;
  logic [31:0] pcc = 32'h100;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .NREG(32)) u32 (
    .clk(clk), .rst(rst),
    .if_valid_i(if_valid), .if_ready_o(o_rdy[0]), .if_instr_i(if_instr), .if_pc_i(if_pc),
    .ex_valid_o(o_vld[0]), .ex_ready_i(ex_ready), .ex_pc_o(o_pc[0]), .ex_instr_o(o_instr[0]),
    .ex_rs1_idx_o(o_rs1i[0]), .ex_rs2_idx_o(o_rs2i[0]), .ex_rd_idx_o(o_rdi[0]),
    .ex_rs1_dat_o(o_rs1d[0]), .ex_rs2_dat_o(o_rs2d[0]), .ex_imm_o(o_imm[0]),
    .ex_op_o(o_op[0]), .ex_funct3_o(o_f3[0]), .ex_illegal_o(o_ill[0]),
    .wb_we_i(wb_we), .wb_rd_i(wb_rd), .wb_dat_i(wb_dat), .flush_i(flush)
  );

  decode_stage #(.XLEN(32), .NREG(16)) u16 (
    .clk(clk), .rst(rst),
    .if_valid_i(if_valid), .if_ready_o(o_rdy[1]), .if_instr_i(if_instr), .if_pc_i(if_pc),
    .ex_valid_o(o_vld[1]), .ex_ready_i(ex_ready), .ex_pc_o(o_pc[1]), .ex_instr_o(o_instr[1]),
    .ex_rs1_idx_o(o_rs1i[1]), .ex_rs2_idx_o(o_rs2i[1]), .ex_rd_idx_o(o_rdi[1]),
    .ex_rs1_dat_o(o_rs1d[1]), .ex_rs2_dat_o(o_rs2d[1]), .ex_imm_o(o_imm[1]),
    .ex_op_o(o_op[1]), .ex_funct3_o(o_f3[1]), .ex_illegal_o(o_ill[1]),
    .wb_we_i(wb_we), .wb_rd_i(wb_rd), .wb_dat_i(wb_dat), .flush_i(flush)
  );

  typedef struct packed {
    logic        vld;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  rs1i;
    logic [4:0]  rs2i;
    logic [4:0]  rdi;
    logic [31:0] rs1d;
    logic [31:0] rs2d;
    logic [31:0] imm;
    logic [3:0]  op;
    logic [2:0]  f3;
    logic        ill;
  } md_t;

  md_t         m [2];
  logic [31:0] mrf [2][32];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // Operand as the execute side must see it at accept time
  function automatic logic [31:0] operand(input int d, input logic [4:0] idx);
    if (BYP && wb_we && wb_rd != 5'd0 && wb_rd == idx) return wb_dat;
    return mrf[d][idx];
  endfunction

  // Decode an instruction word straight from the ISA field layout
  function automatic md_t mdec(input int d, input logic [31:0] ins, input logic [31:0] pc);
    md_t r;
    logic [3:0]  cls;
    logic [31:0] imm;
    bit u1, u2, ud;
    r = '0;
    r.vld = 1'b1; r.pc = pc; r.instr = ins;
    r.rs1i = ins[19:15]; r.rs2i = ins[24:20]; r.rdi = ins[11:7]; r.f3 = ins[14:12];
    cls = OP_ILLEGAL; imm = '0; u1 = 0; u2 = 0; ud = 0;
    case (ins[6:0])
      7'h37: begin cls = OP_LUI;    imm = {ins[31:12], 12'h0}; ud = 1; end
      7'h17: begin cls = OP_AUIPC;  imm = {ins[31:12], 12'h0}; ud = 1; end
      7'h6F: begin cls = OP_JAL;    imm = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0})); ud = 1; end
      7'h67: begin cls = OP_JALR;   imm = 32'($signed(ins[31:20])); u1 = 1; ud = 1; end
      7'h63: begin cls = OP_BRANCH; imm = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0})); u1 = 1; u2 = 1; end
      7'h03: begin cls = OP_LOAD;   imm = 32'($signed(ins[31:20])); u1 = 1; ud = 1; end
      7'h23: begin cls = OP_STORE;  imm = 32'($signed({ins[31:25], ins[11:7]})); u1 = 1; u2 = 1; end
      7'h13: begin cls = OP_OPIMM;  imm = 32'($signed(ins[31:20])); u1 = 1; ud = 1; end
      7'h33: begin cls = OP_OP;     u1 = 1; u2 = 1; ud = 1; end
      7'h0F: cls = OP_FENCE;
      7'h73: cls = OP_SYSTEM;
      default: cls = OP_ILLEGAL;
    endcase
    if (cls == OP_ILLEGAL ||
        (d == 1 && ((u1 && r.rs1i >= 16) || (u2 && r.rs2i >= 16) || (ud && r.rdi >= 16)))) begin
      r.ill = 1'b1; cls = OP_ILLEGAL; imm = '0;
    end
    r.op = cls; r.imm = imm;
    r.rs1d = operand(d, r.rs1i);
    r.rs2d = operand(d, r.rs2i);
    return r;
  endfunction

  // Reference model: advances on every rising edge from the bench inputs
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m[d] <= '0;
        for (int r = 0; r < 32; r++) mrf[d][r] <= '0;
      end else begin
        if (flush) m[d].vld <= 1'b0;
        else if (if_valid && (!m[d].vld || ex_ready)) m[d] <= mdec(d, if_instr, if_pc);
        else if (m[d].vld && !ex_ready) begin
          if (wb_we && wb_rd != 5'd0 && wb_rd == m[d].rs1i) m[d].rs1d <= wb_dat;
          if (wb_we && wb_rd != 5'd0 && wb_rd == m[d].rs2i) m[d].rs2d <= wb_dat;
        end else m[d].vld <= 1'b0;
        if (wb_we && wb_rd != 5'd0 && (d == 0 || wb_rd < 16)) mrf[d][wb_rd] <= wb_dat;
      end
    end
  end

  // Compare both instances against the model on every falling edge
  always @(negedge clk) begin
    if (mon_en) begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("u%0d.valid", d), 32'(o_vld[d]), 32'(m[d].vld));
        chk($sformatf("u%0d.if_ready", d), 32'(o_rdy[d]), 32'(!m[d].vld || ex_ready));
        chk($sformatf("u%0d.pc", d), o_pc[d], m[d].pc);
        chk($sformatf("u%0d.instr", d), o_instr[d], m[d].instr);
        chk($sformatf("u%0d.rs1_idx", d), 32'(o_rs1i[d]), 32'(m[d].rs1i));
        chk($sformatf("u%0d.rs2_idx", d), 32'(o_rs2i[d]), 32'(m[d].rs2i));
        chk($sformatf("u%0d.rd_idx", d), 32'(o_rdi[d]), 32'(m[d].rdi));
        chk($sformatf("u%0d.rs1_dat", d), o_rs1d[d], m[d].rs1d);
        chk($sformatf("u%0d.rs2_dat", d), o_rs2d[d], m[d].rs2d);
        chk($sformatf("u%0d.imm", d), o_imm[d], m[d].imm);
        chk($sformatf("u%0d.op", d), 32'(o_op[d]), 32'(m[d].op));
        chk($sformatf("u%0d.funct3", d), 32'(o_f3[d]), 32'(m[d].f3));
        chk($sformatf("u%0d.illegal", d), 32'(o_ill[d]), 32'(m[d].ill));
      end
    end
  end

  task automatic cyc(input bit v, input logic [31:0] ins, input bit er,
                     input bit we = 1'b0, input logic [4:0] rd = 5'd0,
                     input logic [31:0] dat = 32'd0, input bit fl = 1'b0);
    if_valid = v; if_instr = ins; if_pc = pcc; pcc = pcc + 32'd4;
    ex_ready = er; wb_we = we; wb_rd = rd; wb_dat = dat; flush = fl;
    @(posedge clk);
    #2;
  endtask

  logic [31:0] tbl [17];

  initial begin
    tbl = '{32'hFFB00093, 32'h002101B3, 32'h00628463, 32'hABCDE437, 32'hFE20AE23,
            32'h001000EF, 32'h000100E7, 32'h0080A503, 32'h12345597, 32'h0FF0000F,
            32'h00000073, 32'h00000000, 32'h002088B3, 32'hFFB00090, 32'h0000007F,
            32'h00B50633, 32'h00D48463};

    rst = 1'b1;
    cyc(0, 0, 1);
    cyc(0, 0, 1);
    rst = 1'b0;
    mon_en = 1'b1;
    pcc = 32'h100;
    chk("reset.valid", 32'(o_vld[0]), 32'd0);
    chk("reset.if_ready", 32'(o_rdy[0]), 32'd1);
    chk("reset.imm", o_imm[0], 32'd0);

    // addi x1,x0,-5
    cyc(1, 32'hFFB00093, 1);
    chk("addi.valid", 32'(o_vld[0]), 32'd1);
    chk("addi.op", 32'(o_op[0]), 32'(OP_OPIMM));
    chk("addi.rd", 32'(o_rdi[0]), 32'd1);
    chk("addi.imm", o_imm[0], 32'hFFFFFFFB);
    chk("addi.rs1_dat", o_rs1d[0], 32'd0);
    chk("addi.pc", o_pc[0], 32'h100);

    cyc(0, 0, 1, 1, 5'd2, 32'h1234);
    chk("drain.valid", 32'(o_vld[0]), 32'd0);
    cyc(0, 0, 1, 1, 5'd1, 32'h11);

    // add x3,x2,x2 after x2 written
    cyc(1, 32'h002101B3, 1);
    chk("add.rs1_dat", o_rs1d[0], 32'h1234);
    chk("add.rs2_dat", o_rs2d[0], 32'h1234);
    chk("add.e.rs1_dat", o_rs1d[1], 32'h1234);

    // add x5,x4,x4 with x4 written in the same cycle
    cyc(1, 32'h004202B3, 1, 1, 5'd4, 32'h55);
    chk("samecyc.rs1_dat", o_rs1d[0], BYP ? 32'h55 : 32'h0);
    cyc(1, 32'h004202B3, 1);
    chk("nextcyc.rs1_dat", o_rs1d[0], 32'h55);

    // beq x5,x6,+8 held by a stalled execute stage
    cyc(0, 0, 1);
    cyc(1, 32'h00628463, 0);
    chk("beq.valid", 32'(o_vld[0]), 32'd1);
    chk("beq.if_ready", 32'(o_rdy[0]), 32'd0);
    chk("beq.imm", o_imm[0], 32'd8);
    chk("beq.op", 32'(o_op[0]), 32'(OP_BRANCH));
    cyc(1, 32'h00000333, 0, 1, 5'd5, 32'hAA);
    chk("snoop.rs1_dat", o_rs1d[0], 32'hAA);
    chk("snoop.instr", o_instr[0], 32'h00628463);
    chk("snoop.if_ready", 32'(o_rdy[0]), 32'd0);
    cyc(0, 0, 0, 1, 5'd6, 32'hBB);
    chk("snoop.rs2_dat", o_rs2d[0], 32'hBB);
    cyc(0, 0, 0, 1, 5'd9, 32'h99);
    chk("nosnoop.rs1_dat", o_rs1d[0], 32'hAA);
    chk("nosnoop.rs2_dat", o_rs2d[0], 32'hBB);
    cyc(0, 0, 1);
    chk("release.valid", 32'(o_vld[0]), 32'd0);

    // flush while valid and while a new instruction is accepted
    cyc(1, 32'hABCDE437, 1);
    chk("lui.imm", o_imm[0], 32'hABCDE000);
    chk("lui.op", 32'(o_op[0]), 32'(OP_LUI));
    cyc(1, 32'hFE20AE23, 1, 0, 5'd0, 32'd0, 1);
    chk("flush.valid", 32'(o_vld[0]), 32'd0);
    cyc(0, 0, 1);
    chk("flush.after.valid", 32'(o_vld[0]), 32'd0);

    // back-to-back formats
    cyc(1, 32'hFE20AE23, 1);
    chk("sw.imm", o_imm[0], 32'hFFFFFFFC);
    chk("sw.rs1_dat", o_rs1d[0], 32'h11);
    cyc(1, 32'h001000EF, 1);
    chk("jal.imm", o_imm[0], 32'h800);
    chk("jal.valid", 32'(o_vld[0]), 32'd1);
    cyc(1, 32'h002088B3, 1);
    chk("x17.i.illegal", 32'(o_ill[0]), 32'd0);
    chk("x17.e.illegal", 32'(o_ill[1]), 32'd1);
    chk("x17.e.op", 32'(o_op[1]), 32'(OP_ILLEGAL));
    cyc(1, 32'h00000000, 1);
    chk("zero.i.illegal", 32'(o_ill[0]), 32'd1);
    chk("zero.e.illegal", 32'(o_ill[1]), 32'd1);
    chk("zero.valid", 32'(o_vld[0]), 32'd1);
    cyc(1, 32'hFFB00090, 1);
    chk("lowbits.illegal", 32'(o_ill[0]), 32'd1);

    // mixed stalls, writebacks and one flush, checked by the model
    for (int i = 0; i < 40; i++) begin
      cyc(((i % 4) != 3), tbl[i % 17], ((i % 3) != 2), (i % 2) == 1,
          5'(9 + (i % 7)), $urandom, (i == 13));
    end

    // x0 ignores writes
    cyc(0, 0, 1, 1, 5'd0, 32'hFF);
    cyc(1, 32'h00000333, 1);
    chk("x0.rs1_dat", o_rs1d[0], 32'd0);
    chk("x0.rd", 32'(o_rdi[0]), 32'd6);

    // reset in the middle of a stall
    cyc(0, 0, 1);
    cyc(1, 32'h002083B3, 0);
    chk("prerst.rs1_dat", o_rs1d[0], 32'h11);
    chk("prerst.rs2_dat", o_rs2d[0], 32'h1234);
    rst = 1'b1;
    cyc(0, 0, 0);
    rst = 1'b0;
    chk("rst.valid", 32'(o_vld[0]), 32'd0);
    chk("rst.pc", o_pc[0], 32'd0);
    chk("rst.rs1_dat", o_rs1d[0], 32'd0);
    cyc(1, 32'h002083B3, 1);
    chk("postrst.valid", 32'(o_vld[0]), 32'd1);
    chk("postrst.rs1_dat", o_rs1d[0], 32'd0);
    chk("postrst.rs2_dat", o_rs2d[0], 32'd0);
    cyc(0, 0, 1);

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
